// File: rtl/maxpool_stream_if.sv
// Stream bundle for maxpool_stream: raster samples in, pooled samples out.
// master: upstream side, drives in_*. slave: pooling stage, drives out_*.
// out_index exists only when MAXPOOL_ARGMAX_EN is defined.
interface maxpool_stream_if #(
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int V_BITW     = 9,
    parameter int H_BITW     = 10
);
    logic                        in_enable;
    logic [0:FIXED_BITW*UNITS-1] in_pixels;
    logic [V_BITW-1:0]           in_vcnt;
    logic [H_BITW-1:0]           in_hcnt;

    logic                        out_enable;
    logic [0:FIXED_BITW*UNITS-1] out_pixels;
    logic [V_BITW-1:0]           out_vcnt;
    logic [H_BITW-1:0]           out_hcnt;
`ifdef MAXPOOL_ARGMAX_EN
    logic [0:2*UNITS-1]          out_index;

    modport master (
        output in_enable, in_pixels, in_vcnt, in_hcnt,
        input  out_enable, out_pixels, out_vcnt, out_hcnt, out_index
    );
    modport slave (
        input  in_enable, in_pixels, in_vcnt, in_hcnt,
        output out_enable, out_pixels, out_vcnt, out_hcnt, out_index
    );
`else
    modport master (
        output in_enable, in_pixels, in_vcnt, in_hcnt,
        input  out_enable, out_pixels, out_vcnt, out_hcnt
    );
    modport slave (
        input  in_enable, in_pixels, in_vcnt, in_hcnt,
        output out_enable, out_pixels, out_vcnt, out_hcnt
    );
`endif
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 2x2 signed max-pool: level-LEVEL raster grid in, level-(LEVEL+1) grid out.
// Latency: out_enable pulses 2 clocks after the accepted lower-right (LR) sample.
// No backpressure: accepts one sample per clock, arbitrary gaps; idle cycles hold outputs.
//
// Ports: clock, n_rst (async active-low); st (slave modport of maxpool_stream_if):
//   in_enable/in_pixels/in_vcnt/in_hcnt  - sample stream, full-resolution counters
//   out_enable/out_pixels/out_vcnt/out_hcnt - pooled stream, coords of the UL source
//   out_index (MAXPOOL_ARGMAX_EN only) - 2-bit winning position per channel
// Optional feature macro: MAXPOOL_ARGMAX_EN.
// Channel 0 sits in the MSB-side slice of every pixel bus.
module maxpool_stream #(
    parameter int WIDTH      = -1,
    parameter int HEIGHT     = -1,
    parameter int W_WIDTH    = 640,
    parameter int W_HEIGHT   = 480,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int LEVEL      = 0
) (
    input  logic            clock,
    input  logic            n_rst,
    maxpool_stream_if.slave st
);
    localparam int H_BITW   = $clog2(W_WIDTH);
    localparam int V_BITW   = $clog2(W_HEIGHT);
    localparam int PW       = FIXED_BITW * UNITS;
    localparam int LB_RAW   = W_WIDTH >> (LEVEL + 1);
    localparam int LB_DEPTH = (LB_RAW > 0) ? LB_RAW : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    // Low counter bits that must be zero for a sample to lie on this level's grid.
    localparam logic [V_BITW-1:0] V_GRID = V_BITW'((1 << LEVEL) - 1);
    localparam logic [H_BITW-1:0] H_GRID = H_BITW'((1 << LEVEL) - 1);
    // Output coordinates: LR counters with bits [LEVEL:0] cleared gives the UL corner.
    localparam logic [V_BITW-1:0] V_KEEP = ~V_BITW'((1 << (LEVEL + 1)) - 1);
    localparam logic [H_BITW-1:0] H_KEEP = ~H_BITW'((1 << (LEVEL + 1)) - 1);

    // WIDTH/HEIGHT are informational; a non-negative value must match the frame geometry.
    localparam bit CFG_OK = (LEVEL >= 0) &&
                            ((WIDTH  < 0) || (WIDTH  == (W_WIDTH  >> LEVEL))) &&
                            ((HEIGHT < 0) || (HEIGHT == (W_HEIGHT >> LEVEL)));

    cfg_ok_a: assert property (@(posedge clock) CFG_OK);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        UPPER      = 2'd1,
        LOWER      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             on_grid;
    logic             accept;
    logic             at_origin;
    logic             col;
    logic             row;
    logic             pair_we;
    logic             lb_we;
    logic             emit;
    logic [LB_AW-1:0] lb_addr;

    logic [0:PW-1]    pair_q;
    logic [0:PW-1]    hmax_d;
    logic [0:PW-1]    lb_mem [0:LB_DEPTH-1];

    logic             s1_vld_q;
    logic [0:PW-1]    s1_hmax_q;
    logic [0:PW-1]    lb_rd_q;
    logic [V_BITW-1:0] s1_vcnt_q;
    logic [H_BITW-1:0] s1_hcnt_q;

    logic             out_enable_q;
    logic [0:PW-1]    out_pixels_q;
    logic [0:PW-1]    out_pixels_d;
    logic [V_BITW-1:0] out_vcnt_q;
    logic [H_BITW-1:0] out_hcnt_q;

`ifdef MAXPOOL_ARGMAX_EN
    // Per channel, 1 when the right-hand sample won the horizontal compare.
    logic [0:UNITS-1]   hsel_d;
    logic [0:UNITS-1]   lb_sel_mem [0:LB_DEPTH-1];
    logic [0:UNITS-1]   s1_hsel_q;
    logic [0:UNITS-1]   lb_rdsel_q;
    logic [0:2*UNITS-1] out_index_d;
    logic [0:2*UNITS-1] out_index_q;
`endif

    assign on_grid   = ((st.in_vcnt & V_GRID) == '0) && ((st.in_hcnt & H_GRID) == '0);
    assign accept    = st.in_enable && on_grid;
    assign at_origin = (st.in_vcnt == '0) && (st.in_hcnt == '0);
    assign col       = st.in_hcnt[LEVEL];
    assign row       = st.in_vcnt[LEVEL];
    assign lb_addr   = LB_AW'(st.in_hcnt >> (LEVEL + 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // The sample is processed in the state it moves into, so the first sample of
    // a new row (or the (0,0) resync sample) is already handled as that row's type.
    always_comb begin
        state_d = state_q;
        pair_we = 1'b0;
        lb_we   = 1'b0;
        emit    = 1'b0;
        if (accept) begin
            if (at_origin) begin
                state_d = UPPER;
            end else begin
                case (state_q)
                    UPPER:   if (row)  state_d = LOWER;
                    LOWER:   if (!row) state_d = UPPER;
                    default: state_d = state_q;
                endcase
            end
            pair_we = (state_d != WAIT_FRAME) && !col;
            lb_we   = (state_d == UPPER) && col;
            emit    = (state_d == LOWER) && col;
        end
    end

    // --------------------------------------------------- horizontal stage
    // Ties keep the pair register (left sample).
    always_comb begin
        hmax_d = pair_q;
`ifdef MAXPOOL_ARGMAX_EN
        hsel_d = '0;
`endif
        for (int c = 0; c < UNITS; c++) begin
            if ($signed(st.in_pixels[c*FIXED_BITW +: FIXED_BITW]) >
                $signed(pair_q[c*FIXED_BITW +: FIXED_BITW])) begin
                hmax_d[c*FIXED_BITW +: FIXED_BITW] = st.in_pixels[c*FIXED_BITW +: FIXED_BITW];
`ifdef MAXPOOL_ARGMAX_EN
                hsel_d[c] = 1'b1;
`endif
            end
        end
    end

    // Data-path storage needs no reset: nothing here reaches the outputs before it
    // has been written in the current frame.
    always_ff @(posedge clock) begin
        if (pair_we) begin
            pair_q <= st.in_pixels;
        end
        if (lb_we) begin
            lb_mem[lb_addr] <= hmax_d;
`ifdef MAXPOOL_ARGMAX_EN
            lb_sel_mem[lb_addr] <= hsel_d;
`endif
        end
        if (emit) begin
            s1_hmax_q <= hmax_d;
            lb_rd_q   <= lb_mem[lb_addr];
            s1_vcnt_q <= st.in_vcnt & V_KEEP;
            s1_hcnt_q <= st.in_hcnt & H_KEEP;
`ifdef MAXPOOL_ARGMAX_EN
            s1_hsel_q  <= hsel_d;
            lb_rdsel_q <= lb_sel_mem[lb_addr];
`endif
        end
    end

    // ----------------------------------------------------- vertical stage
    // Upper row (line buffer) is the earlier operand and wins ties.
    always_comb begin
        out_pixels_d = lb_rd_q;
`ifdef MAXPOOL_ARGMAX_EN
        out_index_d = '0;
`endif
        for (int c = 0; c < UNITS; c++) begin
            if ($signed(s1_hmax_q[c*FIXED_BITW +: FIXED_BITW]) >
                $signed(lb_rd_q[c*FIXED_BITW +: FIXED_BITW])) begin
                out_pixels_d[c*FIXED_BITW +: FIXED_BITW] = s1_hmax_q[c*FIXED_BITW +: FIXED_BITW];
`ifdef MAXPOOL_ARGMAX_EN
                out_index_d[2*c +: 2] = {1'b1, s1_hsel_q[c]};
`endif
            end else begin
`ifdef MAXPOOL_ARGMAX_EN
                out_index_d[2*c +: 2] = {1'b0, lb_rdsel_q[c]};
`endif
            end
        end
    end

    // Pipeline valid and outputs are reset so an in-flight result dies with n_rst.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld_q     <= 1'b0;
            out_enable_q <= 1'b0;
            out_pixels_q <= '0;
            out_vcnt_q   <= '0;
            out_hcnt_q   <= '0;
`ifdef MAXPOOL_ARGMAX_EN
            out_index_q  <= '0;
`endif
        end else begin
            s1_vld_q     <= emit;
            out_enable_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_pixels_q <= out_pixels_d;
                out_vcnt_q   <= s1_vcnt_q;
                out_hcnt_q   <= s1_hcnt_q;
`ifdef MAXPOOL_ARGMAX_EN
                out_index_q  <= out_index_d;
`endif
            end
        end
    end

    assign st.out_enable = out_enable_q;
    assign st.out_pixels = out_pixels_q;
    assign st.out_vcnt   = out_vcnt_q;
    assign st.out_hcnt   = out_hcnt_q;
`ifdef MAXPOOL_ARGMAX_EN
    assign st.out_index  = out_index_q;
`endif

endmodule
